display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clock cycles a digit is lit per scan slot (legal: >=2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, meaning all-anodes-off guard cycles between slots (legal: >=1).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port load, input, 1, one-cycle request to capture data_in.
REQ-007 SHALL have port data_in, input, 16, four hex digits; [15:12]=digit 3 ... [3:0]=digit 0.
REQ-008 SHALL have port blank_lz, input, 1, enable leading-zero blanking.
REQ-009 SHALL have port sel, output, 2, index of the digit currently scanned; drives the downstream 4-bit 4:1 digit multiplexer select.
REQ-010 SHALL have ports D0, D1, D2, D3, output, 4 each, committed digit values feeding the multiplexer data inputs.
REQ-011 SHALL have port an, output, 4, active-low one-hot anode enables; an[i] low lights digit i.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse marking a frame commit.

Function
REQ-013 SHALL implement FSM states GUARD and SHOW, plus a slot counter sized for max(CLK_DIV, BLANK_CYCLES).
REQ-014 GUARD SHALL last exactly BLANK_CYCLES cycles with an=4'b1111; on exit sel increments modulo 4 and the FSM enters SHOW.
REQ-015 SHOW SHALL last exactly CLK_DIV cycles with an[sel]=0 and all other anode bits 1 (subject to REQ-019), then enter GUARD with sel unchanged.
REQ-016 All outputs SHALL be registered; an, sel and D0..D3 change only on clock edges and are glitch-free.
REQ-017 load=1 SHALL copy data_in into a shadow register and set a pending flag; a later load in the same frame overwrites the shadow (last load wins).
REQ-018 Commit SHALL occur only on the GUARD->SHOW transition where sel wraps 3->0: if load=1 that cycle, data_in commits directly; else if pending, the shadow commits; pending clears; D0..D3 never change at any other time (no tearing).
REQ-019 With blank_lz=1, digit i (i=3,2,1) SHALL stay dark (an=4'b1111) during its SHOW slot when Di and every higher committed digit are zero; digit 0 is never blanked; blank_lz is sampled each cycle.
REQ-020 frame_done SHALL pulse high for exactly one cycle, the first SHOW cycle of every sel=0 slot, regardless of whether new data committed.
REQ-021 A full scan period SHALL be 4*(CLK_DIV+BLANK_CYCLES) cycles.

Reset
REQ-022 rst=1 SHALL, on the next edge, force state=GUARD, counter=0, sel=2'd3, D0..D3=4'h0, shadow=16'h0, pending=0, an=4'b1111, frame_done=0; rst overrides load.
REQ-023 After rst deasserts, the first SHOW (sel=0, an=4'b1110, frame_done=1) SHALL begin BLANK_CYCLES cycles later; reset mid-SHOW or mid-GUARD discards pending data.

Verification (CLK_DIV=4, BLANK_CYCLES=2)
REQ-024 Reset: hold rst 3 cycles -> an=1111, sel=3, D0..D3=0, frame_done=0; release -> 2 cycles later an=1110, sel=0, frame_done=1 for one cycle.
REQ-025 Scan: data 0 -> an sequence 1110(x4),1111(x2),1101(x4),1111(x2),1011(x4),1111(x2),0111(x4),1111(x2), repeating every 24 cycles.
REQ-026 Deferred commit: load 0x1234 while sel=1 -> D unchanged until wrap; then D3=1, D2=2, D1=3, D0=4 in the frame_done cycle.
REQ-027 Overwrite and collision: loads 0x1111 then 0xABCD in one frame -> only 0xABCD committed; load 0x5A5A in the commit cycle -> D=5,A,5,A immediately.
REQ-028 Blanking: blank_lz=1, data 0x0050 -> digits 3,2 slots an=1111, digit 1 an=1101, digit 0 an=1110; data 0x0000 -> only digit 0 lights.
REQ-029 Reset mid-operation: load 0xFFFF then rst in SHOW before wrap -> D stays 0 after reset, sequence restarts per REQ-023.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Each digit gets a lit SHOW slot followed by an all-dark GUARD slot.
// New digit data is committed only at the frame boundary (sel wraps 3->0)
// so that a frame never shows a mix of old and new digits.
module display_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank_lz,
  output logic [1:0]  sel,
  output logic [3:0]  D0,
  output logic [3:0]  D1,
  output logic [3:0]  D2,
  output logic [3:0]  D3,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      digits_q, digits_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [3:0]       an_q, an_d;
  logic             fd_q, fd_d;

  // A digit is dark when blanking is enabled and it and all higher digits are zero.
  function automatic logic digit_dark(input logic [1:0] idx, input logic [15:0] digs,
                                      input logic en);
    logic dark;
    dark = 1'b0;
    case (idx)
      2'd1:    dark = en && (digs[15:4]  == 12'h000);
      2'd2:    dark = en && (digs[15:8]  == 8'h00);
      2'd3:    dark = en && (digs[15:12] == 4'h0);
      default: dark = 1'b0;
    endcase
    return dark;
  endfunction

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GUARD;
      cnt_q    <= '0;
      sel_q    <= 2'd3;
      digits_q <= 16'h0000;
      shadow_q <= 16'h0000;
      pend_q   <= 1'b0;
      an_q     <= 4'b1111;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      digits_q <= digits_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  // Slot sequencing, shadow capture, frame-boundary commit and next anode pattern.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    sel_d    = sel_q;
    digits_d = digits_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    fd_d     = 1'b0;
    an_d     = 4'b1111;

    if (load) begin
      shadow_d = data_in;
      pend_d   = 1'b1;
    end

    case (state_q)
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          sel_d   = sel_q + 2'd1;
          if (sel_q == 2'd3) begin
            // Frame boundary: a same-cycle load beats an older pending value.
            fd_d   = 1'b1;
            pend_d = 1'b0;
            if (load) begin
              digits_d = data_in;
            end else if (pend_q) begin
              digits_d = shadow_q;
            end
          end
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = GUARD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase

    if ((state_d == SHOW) && !digit_dark(sel_d, digits_d, blank_lz)) begin
      an_d = ~(4'b0001 << sel_d);
    end
  end

  assign sel        = sel_q;
  assign D0         = digits_q[3:0];
  assign D1         = digits_q[7:4];
  assign D2         = digits_q[11:8];
  assign D3         = digits_q[15:12];
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with CLK_DIV=4, BLANK_CYCLES=2.
// The reference model derives every expected output from the number of
// edges since reset using slot arithmetic, plus a frame-level commit model.
module tb_display_scan_ctrl;

  localparam int C = 4;
  localparam int B = 2;
  localparam int SLOT = C + B;
  localparam int P = 4 * SLOT;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        blank_lz;
  logic [1:0]  sel;
  logic [3:0]  d0, d1, d2, d3;
  logic [3:0]  an;
  logic        frame_done;

  display_scan_ctrl #(.CLK_DIV(C), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .blank_lz(blank_lz),
    .sel(sel), .D0(d0), .D1(d1), .D2(d2), .D3(d3), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  int          k = 0;
  logic [15:0] m_d = 16'h0;
  logic [15:0] m_sh = 16'h0;
  logic        m_pend = 1'b0;
  logic        commit_now = 1'b0;
  logic        blz_v = 1'b0;
  logic [1:0]  e_sel;
  logic        e_lit;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic rs);
    int u;
    int r;
    logic [3:0] e_an;
    logic       e_fd;
    load     = ld;
    data_in  = d;
    rst      = rs;
    blank_lz = blz_v;
    @(posedge clk);
    commit_now = 1'b0;
    if (rs) begin
      k = 0; m_d = 16'h0; m_sh = 16'h0; m_pend = 1'b0;
    end else begin
      k++;
      commit_now = (k >= B) && (((k - B) % P) == 0);
      if (commit_now) begin
        if (ld) m_d = d;
        else if (m_pend) m_d = m_sh;
        m_pend = 1'b0;
      end else if (ld) begin
        m_sh = d; m_pend = 1'b1;
      end
    end
    if (k < B) begin
      e_sel = 2'd3; e_lit = 1'b0; r = 1;
    end else begin
      u = k - B;
      e_sel = 2'((u / SLOT) % 4);
      r = u % SLOT;
      e_lit = (r < C);
    end
    e_fd = e_lit && (r == 0) && (e_sel == 2'd0);
    e_an = 4'hF;
    if (e_lit && !(blz_v && (e_sel != 2'd0) && ((m_d >> (4 * e_sel)) == 16'h0)))
      e_an = ~(4'b0001 << e_sel);
    #1;
    chk("an", 16'(an), 16'(e_an));
    chk("sel", 16'(sel), 16'(e_sel));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
    chk("digits", {d3, d2, d1, d0}, m_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic wait_commit();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 16'h0, 1'b0);
      if (commit_now) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_commit", 16'(seen), 16'h1);
  endtask

  initial begin
    load = 1'b0; data_in = 16'h0; rst = 1'b1; blank_lz = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
    chk("rst_an", 16'(an), 16'h000F);
    chk("rst_sel", 16'(sel), 16'h0003);
    chk("rst_fd", 16'(frame_done), 16'h0000);
    chk("rst_digits", {d3, d2, d1, d0}, 16'h0000);

    // First SHOW of digit 0 exactly BLANK_CYCLES after release
    idle(2);
    chk("first_an", 16'(an), 16'h000E);
    chk("first_sel", 16'(sel), 16'h0000);
    chk("first_fd", 16'(frame_done), 16'h0001);
    idle(1);
    chk("fd_one_cycle", 16'(frame_done), 16'h0000);

    // Plain scan over a full period
    idle(P);

    // Deferred commit of a load made in the digit-1 slot
    for (int i = 0; i < 40 && !(e_sel == 2'd1 && e_lit); i++) idle(1);
    chk("reach_sel1", 16'(sel), 16'h0001);
    step(1'b1, 16'h1234, 1'b0);
    chk("deferred_hold", {d3, d2, d1, d0}, 16'h0000);
    wait_commit();
    chk("deferred_commit", {d3, d2, d1, d0}, 16'h1234);
    chk("deferred_fd", 16'(frame_done), 16'h0001);

    // Last load in a frame wins
    step(1'b1, 16'h1111, 1'b0);
    idle(3);
    step(1'b1, 16'hABCD, 1'b0);
    wait_commit();
    chk("overwrite", {d3, d2, d1, d0}, 16'hABCD);

    // Load coinciding with the commit edge goes straight through
    for (int i = 0; i < 30 && (((k + 1 - B) % P) != 0); i++) idle(1);
    step(1'b1, 16'h5A5A, 1'b0);
    chk("collision", {d3, d2, d1, d0}, 16'h5A5A);
    chk("collision_fd", 16'(frame_done), 16'h0001);

    // Leading-zero blanking
    blz_v = 1'b1;
    step(1'b1, 16'h0050, 1'b0);
    wait_commit();
    idle(P);
    step(1'b1, 16'h0000, 1'b0);
    wait_commit();
    idle(P);
    blz_v = 1'b0;

    // Reset before the wrap discards pending data
    step(1'b1, 16'hFFFF, 1'b0);
    idle(2);
    step(1'b0, 16'h0, 1'b1);
    wait_commit();
    chk("rst_discard", {d3, d2, d1, d0}, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) blz_v = ~blz_v;
      step(($urandom_range(7) == 0), 16'($urandom), ($urandom_range(399) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
